sync_fifo_thr: RTL and testbench

SYNC_FIFO_THR -- requirements
Module: sync_fifo_thr

---
 rtl/sync_fifo_pkg.sv | 27 ++
 rtl/fifo_mem_dp.sv | 40 ++++
 rtl/sync_fifo_thr.sv | 170 +++++++++++++++++
 tb/tb_sync_fifo_thr.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants for the thresholded synchronous FIFO:
//   - default data / pointer widths
//   - read-mode encodings (registered read vs first-word-fall-through)
//   - default almost_full margin and almost_empty level
//   - depth helper used to size storage and thresholds
// Optional feature macro used by the FIFO: SYNC_FIFO_THR_ERR_EN
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  // Read-mode encodings for the FWFT parameter.
  localparam int MODE_REG  = 0;
  localparam int MODE_FWFT = 1;

  // almost_full defaults to DEPTH - DEF_AF_MARGIN.
  localparam int DEF_AF_MARGIN = 2;
  localparam int DEF_AE_LVL    = 2;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// -----------------------------------------------------------------------------
// fifo_mem_dp
// Simple dual-port storage array, DEPTH = 2**ADDR_W words of DATA_W bits.
// One synchronous write port, one asynchronous read port, no reset (contents
// are don't-care until written).
// Ports:
//   clk     - write clock
//   w_en    - write strobe
//   w_addr  - write address
//   w_data  - write data
//   r_addr  - read address
//   r_data  - read data (combinational from r_addr)
// -----------------------------------------------------------------------------
module fifo_mem_dp
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (w_en) begin
      mem[w_addr] <= w_data;
    end
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/sync_fifo_thr.sv
// -----------------------------------------------------------------------------
// sync_fifo_thr
// Single-clock FIFO with occupancy count, full/empty and programmable
// almost_full / almost_empty thresholds. Supports a registered-read mode
// (data_out loads on the accepting edge) and a first-word-fall-through mode
// (data_out shows the head entry whenever the FIFO is non-empty).
//
// Optional feature macro: SYNC_FIFO_THR_ERR_EN
//   When defined, adds sticky overflow/underflow error flags and an err_clr
//   input. When undefined those ports do not exist.
//
// Parameters:
//   DATA_W  - data word width
//   ADDR_W  - pointer width, DEPTH = 2**ADDR_W
//   AF_LVL  - almost_full when count >= AF_LVL
//   AE_LVL  - almost_empty when count <= AE_LVL
//   FWFT    - MODE_REG (0) or MODE_FWFT (1)
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-low reset
//   w_en         - write request
//   data_in      - write data
//   r_en         - read request / pop acknowledge in FWFT mode
//   data_out     - read data
//   count        - occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty - registered status flags
//   err_clr      - clears sticky error flags (macro only)
//   overflow     - sticky, set on a rejected write (macro only)
//   underflow    - sticky, set on a rejected read (macro only)
// -----------------------------------------------------------------------------
module sync_fifo_thr
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int AF_LVL = depth_of(ADDR_W) - DEF_AF_MARGIN,
  parameter int AE_LVL = DEF_AE_LVL,
  parameter int FWFT   = MODE_REG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              r_en,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty
`ifdef SYNC_FIFO_THR_ERR_EN
  ,
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam int             DEPTH   = depth_of(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);
  localparam logic           AF_RST  = (AF_LVL <= 0);
  localparam logic           AE_RST  = (AE_LVL >= 0);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_ptr_nxt;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W:0]   count_nxt;
  logic [DATA_W-1:0] dout_nxt;
  logic              wr_acc;
  logic              rd_acc;
  logic              head_is_new;

  // A read needs stored data; a write into a full FIFO is only legal when a
  // read frees a slot on the same edge.
  assign rd_acc = r_en & ~empty;
  assign wr_acc = w_en & (~full | rd_acc);

  assign rd_ptr_nxt = rd_ptr + ADDR_W'(rd_acc);

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + ONE_C;
      2'b01:   count_nxt = count - ONE_C;
      default: count_nxt = count;
    endcase
  end

  // FWFT looks one entry ahead so the new head is ready on the next edge;
  // registered mode reads the current head on the accepting edge.
  assign mem_raddr = (FWFT == MODE_FWFT) ? rd_ptr_nxt : rd_ptr;

  // After this edge the head will be the word being written right now,
  // which is not in the array yet, so it must bypass from data_in.
  assign head_is_new = (count == '0) | ((count == ONE_C) & rd_acc);

  always_comb begin
    dout_nxt = data_out;
    if (FWFT == MODE_FWFT) begin
      if (count_nxt != '0) begin
        dout_nxt = head_is_new ? data_in : mem_rdata;
      end
    end else if (rd_acc) begin
      dout_nxt = mem_rdata;
    end
  end

  fifo_mem_dp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk    (clk),
    .w_en   (wr_acc),
    .w_addr (wr_ptr),
    .w_data (data_in),
    .r_addr (mem_raddr),
    .r_data (mem_rdata)
  );

  // Flags are registered from count_nxt so they always agree with count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= AF_RST;
      almost_empty <= AE_RST;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      data_out     <= dout_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (int'(count_nxt) >= AF_LVL);
      almost_empty <= (int'(count_nxt) <= AE_LVL);
    end
  end

`ifdef SYNC_FIFO_THR_ERR_EN
  // Sticky error flags; a clear on the same edge as a new error wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (err_clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && !wr_acc) begin
        overflow <= 1'b1;
      end
      if (r_en && !rd_acc) begin
        underflow <= 1'b1;
      end
    end
  end
`else
  // No error tracking in this build; rejected requests are silently dropped.
`endif

endmodule

// File: tb/tb_sync_fifo_thr.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_thr
// Two instances (registered-read and FWFT) with DATA_W=8, ADDR_W=2,
// AF_LVL=3, AE_LVL=1. Directed vector tables plus hand-written sequences for
// reset, pointer wrap and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_sync_fifo_thr;

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] din;
    logic       clr;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic [7:0] dout;
    logic       ovf;
    logic       unf;
  } vec_t;

  logic clk;
  logic rst;

  logic       a_w, a_r;
  logic [7:0] a_din, a_dout;
  logic [2:0] a_cnt;
  logic       a_full, a_empty, a_af, a_ae;

  logic       b_w, b_r;
  logic [7:0] b_din, b_dout;
  logic [2:0] b_cnt;
  logic       b_full, b_empty, b_af, b_ae;

`ifdef SYNC_FIFO_THR_ERR_EN
  logic a_clr, a_ovf, a_unf;
  logic b_clr, b_ovf, b_unf;
`endif

  int total = 0;
  int bad   = 0;

  vec_t reg_tab [22];
  vec_t fw_tab  [10];

  sync_fifo_thr #(
    .DATA_W (8), .ADDR_W (2), .AF_LVL (3), .AE_LVL (1), .FWFT (0)
  ) dut_reg (
    .clk          (clk),
    .rst          (rst),
    .w_en         (a_w),
    .data_in      (a_din),
    .r_en         (a_r),
    .data_out     (a_dout),
    .count        (a_cnt),
    .full         (a_full),
    .empty        (a_empty),
    .almost_full  (a_af),
    .almost_empty (a_ae)
`ifdef SYNC_FIFO_THR_ERR_EN
    ,
    .err_clr      (a_clr),
    .overflow     (a_ovf),
    .underflow    (a_unf)
`endif
  );

  sync_fifo_thr #(
    .DATA_W (8), .ADDR_W (2), .AF_LVL (3), .AE_LVL (1), .FWFT (1)
  ) dut_fw (
    .clk          (clk),
    .rst          (rst),
    .w_en         (b_w),
    .data_in      (b_din),
    .r_en         (b_r),
    .data_out     (b_dout),
    .count        (b_cnt),
    .full         (b_full),
    .empty        (b_empty),
    .almost_full  (b_af),
    .almost_empty (b_ae)
`ifdef SYNC_FIFO_THR_ERR_EN
    ,
    .err_clr      (b_clr),
    .overflow     (b_ovf),
    .underflow    (b_unf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_w = 1'b0; a_r = 1'b0; a_din = 8'h00;
    b_w = 1'b0; b_r = 1'b0; b_din = 8'h00;
`ifdef SYNC_FIFO_THR_ERR_EN
    a_clr = 1'b0; b_clr = 1'b0;
`endif
  endtask

  task automatic apply(input vec_t v, input bit fw, input int idx);
    string t;
    t = fw ? $sformatf("fw[%0d]", idx) : $sformatf("reg[%0d]", idx);
    if (fw) begin
      b_w = v.w; b_r = v.r; b_din = v.din;
`ifdef SYNC_FIFO_THR_ERR_EN
      b_clr = v.clr;
`endif
    end else begin
      a_w = v.w; a_r = v.r; a_din = v.din;
`ifdef SYNC_FIFO_THR_ERR_EN
      a_clr = v.clr;
`endif
    end
    tick();
    if (fw) begin
      chk({t, ".count"}, 32'(b_cnt),   32'(v.cnt));
      chk({t, ".full"},  32'(b_full),  32'(v.full));
      chk({t, ".empty"}, 32'(b_empty), 32'(v.empty));
      chk({t, ".af"},    32'(b_af),    32'(v.af));
      chk({t, ".ae"},    32'(b_ae),    32'(v.ae));
      chk({t, ".dout"},  32'(b_dout),  32'(v.dout));
`ifdef SYNC_FIFO_THR_ERR_EN
      chk({t, ".ovf"},   32'(b_ovf),   32'(v.ovf));
      chk({t, ".unf"},   32'(b_unf),   32'(v.unf));
`endif
    end else begin
      chk({t, ".count"}, 32'(a_cnt),   32'(v.cnt));
      chk({t, ".full"},  32'(a_full),  32'(v.full));
      chk({t, ".empty"}, 32'(a_empty), 32'(v.empty));
      chk({t, ".af"},    32'(a_af),    32'(v.af));
      chk({t, ".ae"},    32'(a_ae),    32'(v.ae));
      chk({t, ".dout"},  32'(a_dout),  32'(v.dout));
`ifdef SYNC_FIFO_THR_ERR_EN
      chk({t, ".ovf"},   32'(a_ovf),   32'(v.ovf));
      chk({t, ".unf"},   32'(a_unf),   32'(v.unf));
`endif
    end
  endtask

  logic [7:0] q [$];
  logic [7:0] expd;
  bit         rd, rd_ok, wr_ok;

  initial begin
    //              w  r  din    clr cnt  f  e  af ae dout   ovf unf
    reg_tab[0]  = '{1, 0, 8'h11, 0, 3'd1, 0, 0, 0, 1, 8'h00, 0, 0};
    reg_tab[1]  = '{1, 0, 8'h22, 0, 3'd2, 0, 0, 0, 0, 8'h00, 0, 0};
    reg_tab[2]  = '{1, 0, 8'h33, 0, 3'd3, 0, 0, 1, 0, 8'h00, 0, 0};
    reg_tab[3]  = '{1, 0, 8'h44, 0, 3'd4, 1, 0, 1, 0, 8'h00, 0, 0};
    reg_tab[4]  = '{1, 0, 8'h55, 0, 3'd4, 1, 0, 1, 0, 8'h00, 1, 0};
    reg_tab[5]  = '{0, 1, 8'h00, 0, 3'd3, 0, 0, 1, 0, 8'h11, 1, 0};
    reg_tab[6]  = '{0, 1, 8'h00, 0, 3'd2, 0, 0, 0, 0, 8'h22, 1, 0};
    reg_tab[7]  = '{0, 1, 8'h00, 0, 3'd1, 0, 0, 0, 1, 8'h33, 1, 0};
    reg_tab[8]  = '{0, 1, 8'h00, 0, 3'd0, 0, 1, 0, 1, 8'h44, 1, 0};
    reg_tab[9]  = '{0, 1, 8'h00, 0, 3'd0, 0, 1, 0, 1, 8'h44, 1, 1};
    reg_tab[10] = '{1, 0, 8'h11, 1, 3'd1, 0, 0, 0, 1, 8'h44, 0, 0};
    reg_tab[11] = '{1, 0, 8'h22, 0, 3'd2, 0, 0, 0, 0, 8'h44, 0, 0};
    reg_tab[12] = '{1, 0, 8'h33, 0, 3'd3, 0, 0, 1, 0, 8'h44, 0, 0};
    reg_tab[13] = '{1, 0, 8'h44, 0, 3'd4, 1, 0, 1, 0, 8'h44, 0, 0};
    reg_tab[14] = '{1, 1, 8'h66, 0, 3'd4, 1, 0, 1, 0, 8'h11, 0, 0};
    reg_tab[15] = '{0, 1, 8'h00, 0, 3'd3, 0, 0, 1, 0, 8'h22, 0, 0};
    reg_tab[16] = '{0, 1, 8'h00, 0, 3'd2, 0, 0, 0, 0, 8'h33, 0, 0};
    reg_tab[17] = '{0, 1, 8'h00, 0, 3'd1, 0, 0, 0, 1, 8'h44, 0, 0};
    reg_tab[18] = '{0, 1, 8'h00, 0, 3'd0, 0, 1, 0, 1, 8'h66, 0, 0};
    reg_tab[19] = '{1, 1, 8'h77, 0, 3'd1, 0, 0, 0, 1, 8'h66, 0, 1};
    reg_tab[20] = '{0, 1, 8'h00, 1, 3'd0, 0, 1, 0, 1, 8'h77, 0, 0};
    reg_tab[21] = '{0, 1, 8'h00, 1, 3'd0, 0, 1, 0, 1, 8'h77, 0, 0};

    fw_tab[0]   = '{1, 0, 8'hA5, 0, 3'd1, 0, 0, 0, 1, 8'hA5, 0, 0};
    fw_tab[1]   = '{0, 0, 8'h00, 0, 3'd1, 0, 0, 0, 1, 8'hA5, 0, 0};
    fw_tab[2]   = '{0, 1, 8'h00, 0, 3'd0, 0, 1, 0, 1, 8'hA5, 0, 0};
    fw_tab[3]   = '{1, 0, 8'h01, 0, 3'd1, 0, 0, 0, 1, 8'h01, 0, 0};
    fw_tab[4]   = '{1, 0, 8'h02, 0, 3'd2, 0, 0, 0, 0, 8'h01, 0, 0};
    fw_tab[5]   = '{1, 1, 8'h03, 0, 3'd2, 0, 0, 0, 0, 8'h02, 0, 0};
    fw_tab[6]   = '{0, 1, 8'h00, 0, 3'd1, 0, 0, 0, 1, 8'h03, 0, 0};
    fw_tab[7]   = '{1, 1, 8'h04, 0, 3'd1, 0, 0, 0, 1, 8'h04, 0, 0};
    fw_tab[8]   = '{0, 1, 8'h00, 0, 3'd0, 0, 1, 0, 1, 8'h04, 0, 0};
    fw_tab[9]   = '{0, 1, 8'h00, 0, 3'd0, 0, 1, 0, 1, 8'h04, 0, 1};

    // Reset held for two edges with a write request pending.
    idle_all();
    rst   = 1'b0;
    a_w   = 1'b1; a_din = 8'h99;
    b_w   = 1'b1; b_din = 8'h99;
    tick();
    tick();
    chk("rst.reg.count", 32'(a_cnt),   32'd0);
    chk("rst.reg.empty", 32'(a_empty), 32'd1);
    chk("rst.reg.ae",    32'(a_ae),    32'd1);
    chk("rst.reg.full",  32'(a_full),  32'd0);
    chk("rst.reg.af",    32'(a_af),    32'd0);
    chk("rst.reg.dout",  32'(a_dout),  32'd0);
    chk("rst.fw.count",  32'(b_cnt),   32'd0);
    chk("rst.fw.empty",  32'(b_empty), 32'd1);
    chk("rst.fw.dout",   32'(b_dout),  32'd0);
`ifdef SYNC_FIFO_THR_ERR_EN
    chk("rst.reg.ovf",   32'(a_ovf),   32'd0);
    chk("rst.reg.unf",   32'(a_unf),   32'd0);
`endif
    idle_all();
    rst = 1'b1;

    for (int i = 0; i < 22; i++) apply(reg_tab[i], 1'b0, i);
    idle_all();
    for (int i = 0; i < 10; i++) apply(fw_tab[i], 1'b1, i);
    idle_all();
`ifdef SYNC_FIFO_THR_ERR_EN
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
`endif

    // Stream 0x00..0x09 with interleaved reads through the registered FIFO;
    // ten writes into four slots wraps the pointers twice.
    q.delete();
    for (int i = 0; i < 10; i++) begin
      rd    = (i % 3) != 0;
      rd_ok = rd && (q.size() > 0);
      wr_ok = (q.size() < 4) || rd_ok;
      a_w = 1'b1; a_din = 8'(i); a_r = rd;
      tick();
      if (rd_ok) begin
        expd = q.pop_front();
        chk($sformatf("wrap[%0d].dout", i), 32'(a_dout), 32'(expd));
      end
      if (wr_ok) q.push_back(8'(i));
      chk($sformatf("wrap[%0d].count", i), 32'(a_cnt), 32'(q.size()));
    end
    a_w = 1'b0;
    for (int k = 0; k < 4 && q.size() > 2; k++) begin
      a_r = 1'b1;
      tick();
      expd = q.pop_front();
      chk($sformatf("drain[%0d].dout", k), 32'(a_dout), 32'(expd));
      chk($sformatf("drain[%0d].count", k), 32'(a_cnt), 32'(q.size()));
    end
    idle_all();

    // Asynchronous reset mid-cycle with two entries stored.
    chk("pre_rst.count", 32'(a_cnt), 32'd2);
    rst = 1'b0;
    #1;
    chk("async_rst.count", 32'(a_cnt),   32'd0);
    chk("async_rst.empty", 32'(a_empty), 32'd1);
    chk("async_rst.ae",    32'(a_ae),    32'd1);
    chk("async_rst.dout",  32'(a_dout),  32'd0);
    tick();
    rst = 1'b1;

    // First request after reset is honoured and old entries are gone.
    a_w = 1'b1; a_din = 8'hC3;
    tick();
    chk("post_rst.count", 32'(a_cnt), 32'd1);
    a_w = 1'b0; a_r = 1'b1;
    tick();
    chk("post_rst.dout",  32'(a_dout),  32'hC3);
    chk("post_rst.empty", 32'(a_empty), 32'd1);
    idle_all();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
